// File: rtl/ascii_pkg.sv
// Shared constants, FSM state type and byte-position helper for the ASCII time sender.
package ascii_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_COLON = 8'h3A;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_BUSY,
        WAIT_IDLE,
        DONE
    } state_e;

    // Frame byte index -> nibble position in the snapshot (7 = hour tens, 0 = centisecond units).
    // The three separator indices and the CR/LF indices have no digit; they return 0.
    function automatic logic [2:0] nibble_sel(input logic [3:0] idx);
        logic [2:0] sel;
        case (idx)
            4'd0:    sel = 3'd7;
            4'd1:    sel = 3'd6;
            4'd3:    sel = 3'd5;
            4'd4:    sel = 3'd4;
            4'd6:    sel = 3'd3;
            4'd7:    sel = 3'd2;
            4'd9:    sel = 3'd1;
            default: sel = 3'd0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/bcd_to_ascii.sv
// Converts one BCD nibble to its ASCII digit; nibbles above 9 map to a substitute character.
module bcd_to_ascii
    import ascii_pkg::*;
#(
    parameter logic [7:0] BAD_CHAR = 8'h3F
) (
    input  logic [3:0] nibble_i,
    output logic [7:0] ascii_o
);

    always_comb begin
        ascii_o = BAD_CHAR;
        if (nibble_i <= 4'd9) begin
            ascii_o = ASCII_ZERO + {4'h0, nibble_i};
        end
    end

endmodule

// File: rtl/ascii_time_sender.sv
// Serialises a packed-BCD time snapshot as "HH:MM:SS:CC[\r\n]" into a byte-wide UART
// transmitter, one byte per tx_start / tx_busy handshake.
module ascii_time_sender
    import ascii_pkg::*;
#(
    parameter logic [7:0] SEP_CHAR = ASCII_COLON,
    parameter bit         ADD_CRLF = 1'b1,
    parameter logic [7:0] BAD_CHAR = 8'h3F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        send_start,
    input  logic [31:0] digit_in,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        busy,
    output logic        done
);

    localparam logic [3:0] LastIdx = ADD_CRLF ? 4'd12 : 4'd10;

    state_e      state_q, state_d;
    logic [31:0] snap_q, snap_d;
    logic [3:0]  idx_q, idx_d;
    logic        tx_start_q, tx_start_d;
    logic [7:0]  tx_data_q, tx_data_d;

    logic [2:0]  nib_sel;
    logic [3:0]  nibble;
    logic [7:0]  digit_ascii;
    logic [7:0]  byte_sel;

    assign nib_sel = nibble_sel(idx_q);
    assign nibble  = snap_q[{nib_sel, 2'b00} +: 4];

    bcd_to_ascii #(
        .BAD_CHAR (BAD_CHAR)
    ) u_bcd_to_ascii (
        .nibble_i (nibble),
        .ascii_o  (digit_ascii)
    );

    always_comb begin
        byte_sel = digit_ascii;
        case (idx_q)
            4'd2, 4'd5, 4'd8: byte_sel = SEP_CHAR;
            4'd11:            byte_sel = ASCII_CR;
            4'd12:            byte_sel = ASCII_LF;
            default:          byte_sel = digit_ascii;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (send_start) state_d = SEND;
            SEND:      if (!tx_busy) state_d = WAIT_BUSY;
            WAIT_BUSY: if (tx_busy) state_d = WAIT_IDLE;
            WAIT_IDLE: if (!tx_busy) state_d = (idx_q < LastIdx) ? SEND : DONE;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        snap_d     = snap_q;
        idx_d      = idx_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        busy       = (state_q != IDLE);
        done       = (state_q == DONE);
        tx_start   = tx_start_q;
        tx_data    = tx_data_q;
        if (state_q == IDLE && send_start) begin
            snap_d = digit_in;
            idx_d  = 4'd0;
        end
        if (state_q == SEND && !tx_busy) begin
            tx_start_d = 1'b1;
            tx_data_d  = byte_sel;
        end
        // Index stops at the last byte so it can never wrap into an undefined position.
        if (state_q == WAIT_IDLE && !tx_busy && idx_q < LastIdx) begin
            idx_d = idx_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_q     <= 32'h0;
            idx_q      <= 4'd0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            snap_q     <= snap_d;
            idx_q      <= idx_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

endmodule

// File: tb/tb_ascii_time_sender.sv
// Randomised self-checking bench: a UART busy model per instance and a frame-level reference.
module tb_ascii_time_sender;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Instance A: CR/LF frames; instance B: 11-byte frames.
    logic        a_start, a_txbusy, a_tx_start, a_busy, a_done, a_hold;
    logic [31:0] a_digits;
    logic [7:0]  a_tx_data;
    logic        b_start, b_txbusy, b_tx_start, b_busy, b_done;
    logic [31:0] b_digits;
    logic [7:0]  b_tx_data;

    ascii_time_sender dut_a (
        .clk        (clk),
        .reset      (reset),
        .send_start (a_start),
        .digit_in   (a_digits),
        .tx_busy    (a_txbusy),
        .tx_start   (a_tx_start),
        .tx_data    (a_tx_data),
        .busy       (a_busy),
        .done       (a_done)
    );

    ascii_time_sender #(
        .ADD_CRLF (1'b0)
    ) dut_b (
        .clk        (clk),
        .reset      (reset),
        .send_start (b_start),
        .digit_in   (b_digits),
        .tx_busy    (b_txbusy),
        .tx_start   (b_tx_start),
        .tx_data    (b_tx_data),
        .busy       (b_busy),
        .done       (b_done)
    );

    int total = 0;
    int bad   = 0;

    // UART model: goes busy the cycle after tx_start for len cycles.
    int a_len = 10;
    int a_cnt;
    int b_cnt;
    always @(posedge clk or posedge reset) begin
        if (reset) a_cnt <= 0;
        else if (a_cnt != 0) a_cnt <= a_cnt - 1;
        else if (a_tx_start) a_cnt <= a_len;
    end
    always @(posedge clk or posedge reset) begin
        if (reset) b_cnt <= 0;
        else if (b_cnt != 0) b_cnt <= b_cnt - 1;
        else if (b_tx_start) b_cnt <= 3;
    end
    assign a_txbusy = a_hold | (a_cnt != 0);
    assign b_txbusy = (b_cnt != 0);

    logic [7:0] a_bytes[$];
    logic [7:0] b_bytes[$];
    int a_dones = 0;
    int b_dones = 0;
    always @(negedge clk) begin
        if (a_tx_start) a_bytes.push_back(a_tx_data);
        if (b_tx_start) b_bytes.push_back(b_tx_data);
        if (a_done) a_dones++;
        if (b_done) b_dones++;
    end

    // Reference frame built straight from the byte-order rules.
    logic [7:0] exp_b [0:12];
    int exp_n;

    task automatic ref_frame(input logic [31:0] d, input bit crlf);
        int n;
        exp_n = 0;
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 2; k++) begin
                n = int'((d >> (28 - 8 * p - 4 * k)) & 32'hF);
                exp_b[exp_n] = (n <= 9) ? 8'(48 + n) : 8'h3F;
                exp_n++;
            end
            if (p < 3) begin
                exp_b[exp_n] = 8'h3A;
                exp_n++;
            end
        end
        if (crlf) begin
            exp_b[exp_n] = 8'h0D;
            exp_b[exp_n + 1] = 8'h0A;
            exp_n += 2;
        end
    endtask

    function automatic int first_diff(input int base, input bit use_b);
        for (int i = 0; i < exp_n; i++) begin
            if (use_b) begin
                if (base + i >= b_bytes.size() || b_bytes[base + i] !== exp_b[i]) return i;
            end else begin
                if (base + i >= a_bytes.size() || a_bytes[base + i] !== exp_b[i]) return i;
            end
        end
        return -1;
    endfunction

    task automatic wait_done_a(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (a_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_bytes_a(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (a_bytes.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [31:0] rand_digits();
        return $urandom();
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        a_start = 1'b0; a_digits = '0; a_hold = 1'b0;
        b_start = 1'b0; b_digits = '0;
        repeat (3) @(negedge clk);
        total++;
        if (a_tx_start !== 1'b0 || a_tx_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_tx got start=%b data=%h want 0/00", a_tx_start, a_tx_data);
        end
        total++;
        if (a_busy !== 1'b0 || a_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags got busy=%b done=%b want 0/0", a_busy, a_done);
        end
        total++;
        if (b_tx_start !== 1'b0 || b_tx_data !== 8'h00 || b_busy !== 1'b0 || b_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_b got %b %h %b %b want 0 00 0 0", b_tx_start, b_tx_data, b_busy,
                     b_done);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_frame_a(input logic [31:0] d, input int len, input string tag);
        int base, bd, fd;
        bit ok;
        ref_frame(d, 1'b1);
        a_len = len;
        base = a_bytes.size();
        bd = a_dones;
        a_digits = d;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        total++;
        if (a_busy !== 1'b1) begin
            bad++;
            $display("FAIL %s busy_rise got=%b want=1", tag, a_busy);
        end
        @(negedge clk);
        total++;
        if (a_tx_start !== 1'b1 || a_tx_data !== exp_b[0]) begin
            bad++;
            $display("FAIL %s first_byte got start=%b data=%h want 1/%h", tag, a_tx_start,
                     a_tx_data, exp_b[0]);
        end
        wait_done_a(1000, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s done_timeout got no done want done", tag);
        end
        @(negedge clk);
        total++;
        if (a_done !== 1'b0 || a_busy !== 1'b0) begin
            bad++;
            $display("FAIL %s after_done got done=%b busy=%b want 0/0", tag, a_done, a_busy);
        end
        total++;
        if (a_bytes.size() - base != exp_n) begin
            bad++;
            $display("FAIL %s byte_count got=%0d want=%0d", tag, a_bytes.size() - base, exp_n);
        end
        fd = first_diff(base, 1'b0);
        total++;
        if (fd != -1) begin
            bad++;
            $display("FAIL %s bytes first bad index got=%0d want=-1", tag, fd);
        end
        total++;
        if (a_dones - bd != 1) begin
            bad++;
            $display("FAIL %s done_pulses got=%0d want=1", tag, a_dones - bd);
        end
    endtask

    task automatic test_basic();
        run_frame_a(32'h1234_5678, 10, "basic");
    endtask

    task automatic test_bad_digit();
        run_frame_a(32'h2359_59A9, 10, "bad_digit");
        total++;
        if (exp_b[9] !== 8'h3F || a_bytes[a_bytes.size() - 13 + 9] !== 8'h3F) begin
            bad++;
            $display("FAIL bad_digit idx9 got=%h want=3f", a_bytes[a_bytes.size() - 13 + 9]);
        end
    endtask

    task automatic test_snapshot();
        logic [31:0] d;
        int base, fd;
        bit ok;
        d = rand_digits() | 32'h1000_0000;
        ref_frame(d, 1'b1);
        a_len = 6;
        base = a_bytes.size();
        a_digits = d;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        wait_bytes_a(base + 2, 500, ok);
        a_digits = 32'h0;
        wait_bytes_a(base + 5, 500, ok);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        total++;
        if (a_busy !== 1'b1) begin
            bad++;
            $display("FAIL snapshot busy_mid got=%b want=1", a_busy);
        end
        wait_done_a(1000, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL snapshot done_timeout got no done want done");
        end
        fd = first_diff(base, 1'b0);
        total++;
        if (fd != -1) begin
            bad++;
            $display("FAIL snapshot bytes first bad index got=%0d want=-1", fd);
        end
        repeat (40) @(negedge clk);
        total++;
        if (a_bytes.size() - base != 13 || a_busy !== 1'b0) begin
            bad++;
            $display("FAIL snapshot no_requeue got bytes=%0d busy=%b want 13/0",
                     a_bytes.size() - base, a_busy);
        end
    endtask

    task automatic test_reset_mid();
        int base, sz, nd;
        bit ok;
        a_len = 10;
        base = a_bytes.size();
        a_digits = rand_digits();
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        wait_bytes_a(base + 7, 500, ok);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (a_tx_start !== 1'b0 || a_tx_data !== 8'h00 || a_busy !== 1'b0 || a_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid outputs got %b %h %b %b want 0 00 0 0", a_tx_start,
                     a_tx_data, a_busy, a_done);
        end
        reset = 1'b0;
        sz = a_bytes.size();
        nd = a_dones;
        repeat (30) @(negedge clk);
        total++;
        if (a_bytes.size() != sz || a_dones != nd || a_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid abort got new_bytes=%0d new_dones=%0d busy=%b want 0 0 0",
                     a_bytes.size() - sz, a_dones - nd, a_busy);
        end
        run_frame_a(rand_digits(), 4, "after_reset");
    endtask

    task automatic test_stall();
        logic [31:0] d;
        int base, fd;
        bit ok;
        d = rand_digits();
        ref_frame(d, 1'b1);
        a_len = 5;
        base = a_bytes.size();
        a_hold = 1'b1;
        a_digits = d;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        repeat (50) @(negedge clk);
        total++;
        if (a_bytes.size() != base || a_busy !== 1'b1) begin
            bad++;
            $display("FAIL stall held got bytes=%0d busy=%b want 0/1", a_bytes.size() - base,
                     a_busy);
        end
        a_hold = 1'b0;
        @(negedge clk);
        total++;
        if (a_tx_start !== 1'b1 || a_tx_data !== exp_b[0]) begin
            bad++;
            $display("FAIL stall release got start=%b data=%h want 1/%h", a_tx_start, a_tx_data,
                     exp_b[0]);
        end
        wait_done_a(1000, ok);
        @(negedge clk);
        fd = first_diff(base, 1'b0);
        total++;
        if (!ok || fd != -1 || a_bytes.size() - base != 13) begin
            bad++;
            $display("FAIL stall frame got done=%b bad_idx=%0d count=%0d want 1 -1 13", ok, fd,
                     a_bytes.size() - base);
        end
    endtask

    task automatic test_no_crlf();
        int base, bd, fd;
        bit ok;
        ref_frame(32'h0, 1'b0);
        base = b_bytes.size();
        bd = b_dones;
        b_digits = 32'h0;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (b_done) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
        fd = first_diff(base, 1'b1);
        total++;
        if (!ok || b_dones - bd != 1) begin
            bad++;
            $display("FAIL no_crlf done got seen=%b pulses=%0d want 1/1", ok, b_dones - bd);
        end
        total++;
        if (b_bytes.size() - base != 11 || fd != -1) begin
            bad++;
            $display("FAIL no_crlf frame got count=%0d bad_idx=%0d want 11/-1",
                     b_bytes.size() - base, fd);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 5; i++) begin
            run_frame_a(rand_digits(), int'($urandom_range(1, 12)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_digit();
        test_snapshot();
        test_reset_mid();
        test_stall();
        test_no_crlf();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
